// File: rtl/chunked_addsub_pkg.sv
// Shared types for the chunked add/subtract unit: FSM encoding and the flag
// bundle layout that the ALU flag register also uses.
package chunked_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } flags_t;

  // Chunk counter width; a single-chunk configuration still needs one bit.
  function automatic int cnt_width(int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/chunked_addsub_chunk_adder.sv
// Combinational CHUNK-bit adder with carry-in; also exposes the carry into
// the top bit so the caller can derive signed overflow.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  logic [CHUNK:0] full;

  assign full    = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum     = full[CHUNK-1:0];
  assign cout    = full[CHUNK];
  // Top sum bit is a ^ b ^ carry_in, so the carry in can be recovered from it.
  assign msb_cin = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract: CHUNK bits per clock, carry rippled through a
// register, optional signed saturation, valid/ready on both sides.
module chunked_addsub
  import chunked_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("chunked_addsub: CHUNK (%0d) must divide WIDTH (%0d)", CHUNK, WIDTH);
  end

  state_t state, state_nx;

  logic [NCHUNK-1:0][CHUNK-1:0] a_q, b_q, acc_q, acc_nx;
  logic                         carry_q, sat_q;
  logic [CW-1:0]                cnt;
  logic [WIDTH-1:0]             result_q, final_res;
  flags_t                       flags_q;

  logic [CHUNK-1:0] a_k, b_k, s_k;
  logic             c_k, msb_cin_k, ovf_k, last, accept;

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ST_RUN;
      end
      ST_RUN:  if (last) state_nx = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign busy   = (state != ST_IDLE);
  assign accept = in_valid && in_ready;
  assign last   = (cnt == CW'(NCHUNK - 1));

  // ---------------------------------------------------------------- datapath
  always_comb begin
    a_k = '0;
    b_k = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt == CW'(i)) begin
        a_k = a_q[i];
        b_k = b_q[i];
      end
    end
  end

  chunk_adder #(.CHUNK(CHUNK)) u_adder (
    .a       (a_k),
    .b       (b_k),
    .cin     (carry_q),
    .sum     (s_k),
    .cout    (c_k),
    .msb_cin (msb_cin_k)
  );

  always_comb begin
    acc_nx = acc_q;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt == CW'(i)) acc_nx[i] = s_k;
    end
  end

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf_k = c_k ^ msb_cin_k;

  always_comb begin
    final_res = acc_nx;
    if (sat_q && ovf_k)
      final_res = a_k[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  // NOTE: operand/accumulator registers carry no reset: they are always loaded
  // at the accept edge before being read, and only the FSM gates their use.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q     <= op_a;
      b_q     <= op_b ^ {WIDTH{sub}};
      carry_q <= sub;
      sat_q   <= sat;
      cnt     <= '0;
    end else if (state == ST_RUN) begin
      acc_q   <= acc_nx;
      carry_q <= c_k;
      if (!last) cnt <= cnt + 1'b1;
    end
  end

  // Visible outputs change only when an operation completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (state == ST_RUN && last) begin
      result_q         <= final_res;
      flags_q.carry    <= c_k;
      flags_q.overflow <= ovf_k;
      flags_q.zero     <= (final_res == '0);
      flags_q.negative <= final_res[WIDTH-1];
    end
  end

  assign result    = result_q;
  assign carry_out = flags_q.carry;
  assign overflow  = flags_q.overflow;
  assign zero      = flags_q.zero;
  assign negative  = flags_q.negative;

endmodule

// File: tb/tb_chunked_addsub.sv
// Self-checking bench: three configurations (32/8, 16/16, 64/4) against an
// arithmetic reference model, plus directed, backpressure and reset cases.
module tb_chunked_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  in_valid;
  logic        out_ready;
  logic [63:0] op_a, op_b;
  logic        sub, sat;

  logic [2:0]  in_ready, out_valid, carry, ovf, zero, neg, busy;
  logic [31:0] r0;
  logic [15:0] r1;
  logic [63:0] r2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  chunked_addsub #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .op_a(op_a[31:0]), .op_b(op_b[31:0]), .sub(sub), .sat(sat),
    .out_valid(out_valid[0]), .out_ready(out_ready), .result(r0),
    .carry_out(carry[0]), .overflow(ovf[0]), .zero(zero[0]),
    .negative(neg[0]), .busy(busy[0])
  );

  chunked_addsub #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .op_a(op_a[15:0]), .op_b(op_b[15:0]), .sub(sub), .sat(sat),
    .out_valid(out_valid[1]), .out_ready(out_ready), .result(r1),
    .carry_out(carry[1]), .overflow(ovf[1]), .zero(zero[1]),
    .negative(neg[1]), .busy(busy[1])
  );

  chunked_addsub #(.WIDTH(64), .CHUNK(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .op_a(op_a), .op_b(op_b), .sub(sub), .sat(sat),
    .out_valid(out_valid[2]), .out_ready(out_ready), .result(r2),
    .carry_out(carry[2]), .overflow(ovf[2]), .zero(zero[2]),
    .negative(neg[2]), .busy(busy[2])
  );

  typedef struct packed {
    logic [63:0] res;
    logic [3:0]  flags;   // {carry, overflow, zero, negative}
  } exp_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int width_of(int d);
    return (d == 0) ? 32 : (d == 1) ? 16 : 64;
  endfunction

  function automatic int nchunk_of(int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : 16;
  endfunction

  function automatic logic [63:0] mask_of(int w);
    return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] res_of(int d);
    return (d == 0) ? {32'h0, r0} : (d == 1) ? {48'h0, r1} : r2;
  endfunction

  function automatic logic [3:0] flags_of(int d);
    return {carry[d], ovf[d], zero[d], neg[d]};
  endfunction

  // Reference: exact signed/unsigned arithmetic on wide integers.
  function automatic exp_t model(int w, logic [63:0] a, logic [63:0] b, logic s, logic st);
    exp_t               e;
    logic signed [65:0] sa, sb, sr, hi, lo;
    logic [64:0]        usum;
    logic [63:0]        r;
    logic               c, v;
    sa = $signed({2'b00, a});
    sb = $signed({2'b00, b});
    if (a[w-1]) sa = sa - (66'sd1 <<< w);
    if (b[w-1]) sb = sb - (66'sd1 <<< w);
    sr = s ? (sa - sb) : (sa + sb);
    hi = (66'sd1 <<< (w - 1)) - 66'sd1;
    lo = -(66'sd1 <<< (w - 1));
    v  = (sr > hi) || (sr < lo);
    usum = {1'b0, a} + {1'b0, b};
    c  = s ? (a >= b) : usum[w];
    if (st && v) r = (sr > hi) ? hi[63:0] : lo[63:0];
    else         r = sr[63:0];
    r  = r & mask_of(w);
    e.res   = r;
    e.flags = {c, v, (r == 64'h0), r[w-1]};
    return e;
  endfunction

  function automatic logic [63:0] pick(int w);
    logic [63:0] m, x;
    m = mask_of(w);
    case ($urandom_range(0, 7))
      0:       x = m;
      1:       x = 64'd1 << (w - 1);
      2:       x = (64'd1 << (w - 1)) - 64'd1;
      3:       x = 64'd0;
      4:       x = 64'd1;
      default: x = {$urandom, $urandom};
    endcase
    return x & m;
  endfunction

  // Issue one op on dut d, check latency, return outputs; drains if out_ready.
  task automatic run_op(input int d, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input logic st, input string tag,
                        output logic [63:0] got_res, output logic [3:0] got_flags);
    int lat;
    @(negedge clk);
    op_a = a;
    op_b = b;
    sub  = s;
    sat  = st;
    in_valid[d] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    op_a = {$urandom, $urandom};
    op_b = {$urandom, $urandom};
    lat = 0;
    while (!out_valid[d] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(nchunk_of(d)));
    got_res   = res_of(d);
    got_flags = flags_of(d);
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic st,
                          input logic [31:0] exp_res, input logic [3:0] exp_flags);
    logic [63:0] gr;
    logic [3:0]  gf;
    run_op(0, {32'h0, a}, {32'h0, b}, s, st, tag, gr, gf);
    check({tag, " result"}, gr, {32'h0, exp_res});
    check({tag, " flags"}, {60'h0, gf}, {60'h0, exp_flags});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] gr;
    logic [3:0]  gf;
    exp_t        e;
    logic [63:0] a, b;
    logic        s, st;

    rst_n = 1'b0;
    in_valid = 3'b000;
    out_ready = 1'b1;
    op_a = '0;
    op_b = '0;
    sub = 1'b0;
    sat = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset d%0d ctrl", d),
            {61'h0, in_ready[d], out_valid[d], busy[d]}, 64'b100);
      check($sformatf("reset d%0d result", d), res_of(d), 64'h0);
      check($sformatf("reset d%0d flags", d), {60'h0, flags_of(d)}, 64'h0);
    end
    rst_n = 1'b1;

    // Directed cases on the 32/8 configuration; flags are {c, v, z, n}.
    directed("ff+1",      32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 4'b0000);
    directed("ripple",    32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 4'b1010);
    directed("ovf wrap",  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 4'b0101);
    directed("ovf sat",   32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 4'b0100);
    directed("5-7",       32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 4'b0001);
    directed("min-1 sat", 32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h80000000, 4'b1101);
    directed("9-9",       32'h00000009, 32'h00000009, 1'b1, 1'b0, 32'h00000000, 4'b1010);

    // Backpressure: result held in DONE, in_valid pulses ignored.
    out_ready = 1'b0;
    run_op(0, 64'h12345678, 64'h11111111, 1'b0, 1'b0, "bp", gr, gf);
    check("bp result", gr, 64'h23456789);
    for (int i = 0; i < 3; i++) begin
      op_a = {$urandom, $urandom};
      op_b = {$urandom, $urandom};
      in_valid[0] = 1'b1;
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      check("bp hold", {28'h0, flags_of(0), res_of(0)[31:0]}, {28'h0, 4'b0000, 32'h23456789});
      check("bp in_ready", {63'h0, in_ready[0]}, 64'h0);
      check("bp out_valid", {63'h0, out_valid[0]}, 64'h1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release", {62'h0, out_valid[0], in_ready[0]}, 64'b01);
    check("bp after", res_of(0), 64'h23456789);

    // Reset on the second RUN cycle aborts the operation.
    @(negedge clk);
    op_a = 64'h0000_0000_1111_1111;
    op_b = 64'h0000_0000_2222_2222;
    sub = 1'b0;
    sat = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    check("run busy", {63'h0, busy[0]}, 64'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort ctrl", {61'h0, in_ready[0], out_valid[0], busy[0]}, 64'b100);
    check("abort result", res_of(0), 64'h0);
    rst_n = 1'b1;
    directed("3+4", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 4'b0000);

    // Randomized sweep against the reference model.
    for (int d = 0; d < 3; d++) begin
      int n_ops;
      n_ops = (d == 0) ? 300 : 1000;
      for (int i = 0; i < n_ops; i++) begin
        a  = pick(width_of(d));
        b  = pick(width_of(d));
        s  = 1'($urandom_range(0, 1));
        st = 1'($urandom_range(0, 1));
        e  = model(width_of(d), a, b, s, st);
        run_op(d, a, b, s, st, $sformatf("rnd d%0d", d), gr, gf);
        if (gr !== e.res)
          check($sformatf("rnd d%0d result a=%h b=%h sub=%0b sat=%0b", d, a, b, s, st), gr, e.res);
        else
          check($sformatf("rnd d%0d result", d), gr, e.res);
        check($sformatf("rnd d%0d flags a=%h b=%h sub=%0b sat=%0b", d, a, b, s, st),
              {60'h0, gf}, {60'h0, e.flags});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chunked_addsub.md
Name: chunked_addsub

Overview:
Parametrised multi-cycle add/subtract unit and the successor of the single-cycle 32-bit adder. It processes a WIDTH-bit operation CHUNK bits per clock, rippling the carry through a register, and reports carry, signed overflow, zero and negative flags. An optional saturating mode is provided. Valid/ready handshakes on both sides let it sit between the register-read stage and the ALU result mux, or on the FPGA test harness behind switches and keys.

Parameters:
WIDTH, 32, operand and result width in bits.
CHUNK, 8, bits summed per cycle. Must divide WIDTH; a violation fails elaboration.
NCHUNK, WIDTH/CHUNK, derived (localparam), so latency = NCHUNK cycles.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operands and mode present
in_ready  out  1  block can accept an operation
op_a  in  WIDTH  first operand
op_b  in  WIDTH  second operand
sub  in  1  0 = A+B, 1 = A-B
sat  in  1  1 = signed saturate on overflow
out_valid  out  1  result and flags valid
out_ready  in  1  consumer takes the result
result  out  WIDTH  sum or difference, post-saturation
carry_out  out  1  raw carry out of the MSB (sub: 1 = no borrow)
overflow  out  1  signed overflow of the unsaturated result
zero  out  1  result == 0, post-saturation
negative  out  1  result[WIDTH-1], post-saturation
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst_n low at a clk edge):
  - FSM goes to IDLE.
  - result, carry_out, overflow, zero, negative, out_valid and busy are all 0; in_ready is 1.
  - Reset during RUN or DONE aborts the operation. No partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - Accept on in_valid & in_ready. At that edge, latch op_a, op_b ^ {WIDTH{sub}}, carry register = sub, sat, chunk counter = 0, then go to RUN.
  - Inputs are sampled only at the accept edge and ignored at all other times.
- RUN:
  - in_ready = 0.
  - Each cycle: {c, s} = A[k] + B'[k] + carry, where k is the chunk counter and chunks are taken LSB first.
  - s is written into result chunk k, carry is registered, and the counter increments.
  - On the edge that processes chunk NCHUNK-1:
    - compute overflow = (A_msb == B'_msb) & (s_msb != A_msb);
    - carry_out = final carry;
    - if sat & overflow, result = A_msb ? {1,0...0} : {0,1...1};
    - zero and negative are computed from the final result;
    - go to DONE.
- DONE:
  - out_valid = 1. result and flags are held stable until out_ready.
  - On out_valid & out_ready, go to IDLE and drop out_valid.
  - There is no same-cycle back-to-back accept: in_ready rises the cycle after the handshake.
- Latency: out_valid rises exactly NCHUNK clocks after the accept edge.
  - The minimum issue interval is NCHUNK+2 cycles when out_ready is held high.
- CHUNK == WIDTH is the degenerate case: one RUN cycle, latency 1.
- Arithmetic is modulo 2^WIDTH. Flags are meaningful only while out_valid is high, but are held until the next operation completes.
- Counter width is clog2(NCHUNK), minimum 1 bit. It never wraps past NCHUNK-1.

Decomposition:
- Shared package/header holds:
  - FSM state encodings ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2;
  - the flag-bundle ordering {carry, overflow, zero, negative}, shared with the ALU flag register.
- One natural sub-module: chunk_adder. It is a combinational CHUNK-bit adder with carry-in, returning sum, carry-out and MSB-stage carry-in. It is instantiated once and muxed by the chunk counter.

Test Plan:
- 0x000000FF + 0x00000001, sub=0, sat=0 -> result 0x00000100; carry 0, ovf 0, zero 0; out_valid exactly 4 clocks after accept.
- 0xFFFFFFFF + 0x00000001 -> result 0x00000000; carry 1, zero 1, ovf 0. Confirms the carry ripples through all four chunks.
- 0x7FFFFFFF + 0x00000001: with sat=0 -> 0x80000000, ovf 1, neg 1. With sat=1 -> 0x7FFFFFFF, ovf 1, neg 0.
- Subtraction cases:
  - 5 - 7, sub=1 -> 0xFFFFFFFE, carry 0, neg 1.
  - 0x80000000 - 1, sat=1 -> 0x80000000, ovf 1.
  - 9 - 9 -> 0, carry 1, zero 1.
- Backpressure and reset:
  - Hold out_ready=0 for 3 cycles in DONE -> result and flags stable, in_ready 0, in_valid pulses ignored. Release -> one handshake, then in_ready 1 on the next cycle.
  - rst_n low on the 2nd RUN cycle -> next cycle out_valid 0, busy 0, in_ready 1. The following op 3+4 returns 7.
- Parameter sweep: WIDTH=16/CHUNK=16 (latency 1) and WIDTH=64/CHUNK=4 (latency 16). Run 1000 random ops each against a reference model of A±B with flags.
